// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset control FSM.
package cpu_ctrl_pkg;

   localparam int unsigned OPCODE_W = 7;
   localparam int unsigned ALU_OP_W = 2;
   localparam int unsigned CAUSE_W  = 2;
   localparam int unsigned WAIT_W   = 8;

   typedef enum logic [3:0] {
      RST, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR,
      MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP
   } state_t;

   typedef enum logic [2:0] {
      CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_ILLEGAL
   } instr_class_t;

   localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

   localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [ALU_OP_W-1:0] ALU_OP_RTYPE = 2'b10;
   localparam logic [ALU_OP_W-1:0] ALU_OP_ADDI  = 2'b11;

   localparam logic [CAUSE_W-1:0] CAUSE_NONE        = 2'b00;
   localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL     = 2'b01;
   localparam logic [CAUSE_W-1:0] CAUSE_MEM_TIMEOUT = 2'b10;

   // States that issue a memory request and wait on mem_ready.
   function automatic logic is_mem_state(state_t s);
      return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and the shared datapath/memory.
interface multicycle_control_if;
   import cpu_ctrl_pkg::*;

   logic [OPCODE_W-1:0] opcode;
   logic                zero;
   logic                mem_ready;
   logic                mem_read;
   logic                mem_write;
   logic                i_or_d;
   logic                ir_write;
   logic                pc_write;
   logic                pc_src;
   logic                alu_src_a;
   logic                alu_src_b;
   logic [ALU_OP_W-1:0] alu_op;
   logic                reg_write;
   logic                mem_to_reg;

   modport master (
      input  opcode, zero, mem_ready,
      output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
             alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
             alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg
   );
endinterface

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode classifier: instruction class, ALU-op code and legality.
module ctrl_opcode_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   output instr_class_t        instr_class,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                legal
);

   always_comb begin
      instr_class = CLS_ILLEGAL;
      alu_op      = ALU_OP_ADD;
      legal       = 1'b1;
      case (opcode)
         OP_R:      begin instr_class = CLS_R;      alu_op = ALU_OP_RTYPE; end
         OP_I:      begin instr_class = CLS_I;      alu_op = ALU_OP_ADDI;  end
         OP_LOAD:   begin instr_class = CLS_LOAD;   alu_op = ALU_OP_ADD;   end
         OP_STORE:  begin instr_class = CLS_STORE;  alu_op = ALU_OP_ADD;   end
         OP_BRANCH: begin instr_class = CLS_BRANCH; alu_op = ALU_OP_SUB;   end
         default:   legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM sequencing the shared datapath over several cycles per instruction,
// with memory wait-state watchdog, sticky trap and retired-instruction counter.
module multicycle_control
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_control_if.master bus,
   output logic [CNT_W-1:0]     retired,
   output logic                 trap,
   output logic [CAUSE_W-1:0]   trap_cause
);

   state_t              state;
   state_t              state_next;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [ALU_OP_W-1:0] alu_op_q;
   logic [CAUSE_W-1:0]  trap_cause_q;
   logic [CAUSE_W-1:0]  cause_next;
   logic [CNT_W-1:0]    retired_q;
   logic                retire;
   logic                timeout;

   instr_class_t        dec_class;
   logic [ALU_OP_W-1:0] dec_alu_op;
   logic                dec_legal;

   ctrl_opcode_decode u_decode (
      .opcode      (bus.opcode),
      .instr_class (dec_class),
      .alu_op      (dec_alu_op),
      .legal       (dec_legal)
   );

   // Transfer wins over the watchdog when both land on the same edge.
   assign timeout = !bus.mem_ready && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= RST;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      cause_next = CAUSE_NONE;
      retire     = 1'b0;
      case (state)
         RST:      state_next = FETCH;
         FETCH: begin
            if (bus.mem_ready) state_next = DECODE;
            else if (timeout) begin state_next = TRAP; cause_next = CAUSE_MEM_TIMEOUT; end
         end
         DECODE: begin
            if (!dec_legal) begin
               state_next = TRAP;
               cause_next = CAUSE_ILLEGAL;
            end else begin
               case (dec_class)
                  CLS_R:                state_next = EXEC_R;
                  CLS_I:                state_next = EXEC_I;
                  CLS_LOAD, CLS_STORE:  state_next = MEM_ADDR;
                  CLS_BRANCH:           state_next = BRANCH;
                  default: begin state_next = TRAP; cause_next = CAUSE_ILLEGAL; end
               endcase
            end
         end
         EXEC_R, EXEC_I: state_next = WB_ALU;
         MEM_ADDR:       state_next = (dec_class == CLS_LOAD) ? MEM_RD : MEM_WR;
         MEM_RD: begin
            if (bus.mem_ready) state_next = WB_MEM;
            else if (timeout) begin state_next = TRAP; cause_next = CAUSE_MEM_TIMEOUT; end
         end
         MEM_WR: begin
            if (bus.mem_ready) begin state_next = FETCH; retire = 1'b1; end
            else if (timeout) begin state_next = TRAP; cause_next = CAUSE_MEM_TIMEOUT; end
         end
         WB_ALU, WB_MEM, BRANCH: begin
            state_next = FETCH;
            retire     = 1'b1;
         end
         TRAP:    state_next = TRAP;
         default: state_next = RST;
      endcase
   end

   always_comb begin
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.i_or_d     = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_src     = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 1'b0;
      bus.alu_op     = ALU_OP_ADD;
      bus.reg_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      trap           = 1'b0;
      case (state)
         FETCH: begin
            bus.mem_read = 1'b1;
            bus.ir_write = bus.mem_ready;
            bus.pc_write = bus.mem_ready;
         end
         DECODE:   bus.alu_op = dec_alu_op;
         EXEC_R: begin bus.alu_src_a = 1'b1; bus.alu_op = alu_op_q; end
         EXEC_I, MEM_ADDR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 1'b1;
            bus.alu_op    = alu_op_q;
         end
         MEM_RD: begin bus.mem_read  = 1'b1; bus.i_or_d = 1'b1; end
         MEM_WR: begin bus.mem_write = 1'b1; bus.i_or_d = 1'b1; end
         WB_ALU:   bus.reg_write = 1'b1;
         WB_MEM: begin bus.reg_write = 1'b1; bus.mem_to_reg = 1'b1; end
         BRANCH: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = alu_op_q;
            bus.pc_write  = bus.zero;
            bus.pc_src    = 1'b1;
         end
         TRAP:    trap = 1'b1;
         default: ;
      endcase
   end

   // Wait counter, held ALU-op, trap cause and retire counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt     <= '0;
         alu_op_q     <= ALU_OP_ADD;
         trap_cause_q <= CAUSE_NONE;
         retired_q    <= '0;
      end else begin
         if (state_next != state)
            wait_cnt <= '0;
         else if (is_mem_state(state) && !bus.mem_ready)
            wait_cnt <= wait_cnt + WAIT_W'(1);
         if (state == DECODE)
            alu_op_q <= dec_alu_op;
         if (state != TRAP && state_next == TRAP)
            trap_cause_q <= cause_next;
         if (retire)
            retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign retired    = retired_q;
   assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (MEM_TIMEOUT=4, CNT_W=4).
module tb_multicycle_control;
   import cpu_ctrl_pkg::*;

   localparam int unsigned TB_CNT_W = 4;

   // ctl = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op[1:0], reg_write, mem_to_reg, trap}
   localparam logic [12:0] C_IDLE     = 13'b0_0_0_0_0_0_0_0_00_0_0_0;
   localparam logic [12:0] C_FETCH_W  = 13'b1_0_0_0_0_0_0_0_00_0_0_0;
   localparam logic [12:0] C_FETCH_GO = 13'b1_0_0_1_1_0_0_0_00_0_0_0;
   localparam logic [12:0] C_DEC_R    = 13'b0_0_0_0_0_0_0_0_10_0_0_0;
   localparam logic [12:0] C_EXEC_R   = 13'b0_0_0_0_0_0_1_0_10_0_0_0;
   localparam logic [12:0] C_WB_ALU   = 13'b0_0_0_0_0_0_0_0_00_1_0_0;
   localparam logic [12:0] C_MEM_ADDR = 13'b0_0_0_0_0_0_1_1_00_0_0_0;
   localparam logic [12:0] C_MEM_RD   = 13'b1_0_1_0_0_0_0_0_00_0_0_0;
   localparam logic [12:0] C_MEM_WR   = 13'b0_1_1_0_0_0_0_0_00_0_0_0;
   localparam logic [12:0] C_WB_MEM   = 13'b0_0_0_0_0_0_0_0_00_1_1_0;
   localparam logic [12:0] C_DEC_B    = 13'b0_0_0_0_0_0_0_0_01_0_0_0;
   localparam logic [12:0] C_BR_T     = 13'b0_0_0_0_1_1_1_0_01_0_0_0;
   localparam logic [12:0] C_BR_N     = 13'b0_0_0_0_0_1_1_0_01_0_0_0;
   localparam logic [12:0] C_TRAP     = 13'b0_0_0_0_0_0_0_0_00_0_0_1;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [TB_CNT_W-1:0] retired;
   logic                trap;
   logic [1:0]          trap_cause;
   logic [12:0]         ctl;
   int                  n_checks = 0;
   int                  n_fail   = 0;

   multicycle_control_if bus ();

   multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(TB_CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .retired    (retired),
      .trap       (trap),
      .trap_cause (trap_cause)
   );

   always #5 clk = ~clk;

   assign ctl = {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write, bus.pc_src,
                 bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write, bus.mem_to_reg, trap};

   task automatic test_reset();
      rst_n = 1'b0; bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (dut.state !== RST) begin n_fail++; $display("FAIL reset_state got %0d want %0d", dut.state, RST); end
      n_checks++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL reset_ctl got %b want %b", ctl, C_IDLE); end
      n_checks++; if (retired !== 4'd0 || trap_cause !== 2'b00) begin
         n_fail++; $display("FAIL reset_regs got retired=%0d cause=%b want 0/00", retired, trap_cause); end
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_checks++; if (dut.state !== FETCH) begin n_fail++; $display("FAIL reset_exit got %0d want %0d", dut.state, FETCH); end
   endtask

   task automatic test_rtype();
      state_t      st [4];
      logic [12:0] ec [4];
      st = '{FETCH, DECODE, EXEC_R, WB_ALU};
      ec = '{C_FETCH_GO, C_DEC_R, C_EXEC_R, C_WB_ALU};
      bus.opcode = OP_R; bus.mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (dut.state !== st[i]) begin n_fail++; $display("FAIL rtype_state c%0d got %0d want %0d", i, dut.state, st[i]); end
         n_checks++; if (ctl !== ec[i]) begin n_fail++; $display("FAIL rtype_ctl c%0d got %b want %b", i, ctl, ec[i]); end
         @(negedge clk);
      end
      #1;
      n_checks++; if (dut.state !== FETCH || retired !== 4'd1) begin
         n_fail++; $display("FAIL rtype_retire got state=%0d retired=%0d want %0d/1", dut.state, retired, FETCH); end
   endtask

   task automatic test_lw();
      state_t      st  [10];
      logic [12:0] ec  [10];
      logic        rdy [10];
      st  = '{FETCH, FETCH, FETCH, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_RD, MEM_RD, WB_MEM};
      ec  = '{C_FETCH_W, C_FETCH_W, C_FETCH_W, C_FETCH_GO, C_IDLE, C_MEM_ADDR,
              C_MEM_RD, C_MEM_RD, C_MEM_RD, C_WB_MEM};
      rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      bus.opcode = OP_LOAD;
      for (int i = 0; i < 10; i++) begin
         bus.mem_ready = rdy[i];
         #1;
         n_checks++; if (dut.state !== st[i]) begin n_fail++; $display("FAIL lw_state c%0d got %0d want %0d", i, dut.state, st[i]); end
         n_checks++; if (ctl !== ec[i]) begin n_fail++; $display("FAIL lw_ctl c%0d got %b want %b", i, ctl, ec[i]); end
         @(negedge clk);
      end
      #1;
      n_checks++; if (dut.state !== FETCH || retired !== 4'd2) begin
         n_fail++; $display("FAIL lw_retire got state=%0d retired=%0d want %0d/2", dut.state, retired, FETCH); end
   endtask

   task automatic test_beq();
      state_t      st [6];
      logic [12:0] ec [6];
      logic        zr [6];
      st = '{FETCH, DECODE, BRANCH, FETCH, DECODE, BRANCH};
      ec = '{C_FETCH_GO, C_DEC_B, C_BR_T, C_FETCH_GO, C_DEC_B, C_BR_N};
      zr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      bus.opcode = OP_BRANCH; bus.mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.zero = zr[i];
         #1;
         n_checks++; if (dut.state !== st[i]) begin n_fail++; $display("FAIL beq_state c%0d got %0d want %0d", i, dut.state, st[i]); end
         n_checks++; if (ctl !== ec[i]) begin n_fail++; $display("FAIL beq_ctl c%0d got %b want %b", i, ctl, ec[i]); end
         @(negedge clk);
      end
      #1;
      n_checks++; if (retired !== 4'd4) begin n_fail++; $display("FAIL beq_retire got %0d want 4", retired); end
   endtask

   task automatic test_wrap();
      bus.opcode = OP_BRANCH; bus.mem_ready = 1'b1; bus.zero = 1'b0;
      for (int k = 0; k < 12; k++) begin
         repeat (3) @(negedge clk);
         #1;
         if (k == 10) begin
            n_checks++; if (retired !== 4'd15) begin n_fail++; $display("FAIL wrap_max got %0d want 15", retired); end
         end
         if (k == 11) begin
            n_checks++; if (retired !== 4'd0 || dut.state !== FETCH) begin
               n_fail++; $display("FAIL wrap_zero got retired=%0d state=%0d want 0/%0d", retired, dut.state, FETCH); end
         end
      end
   endtask

   task automatic test_sw_ready_at_limit();
      state_t      st  [7];
      logic [12:0] ec  [7];
      logic        rdy [7];
      st  = '{FETCH, DECODE, MEM_ADDR, MEM_WR, MEM_WR, MEM_WR, MEM_WR};
      ec  = '{C_FETCH_GO, C_IDLE, C_MEM_ADDR, C_MEM_WR, C_MEM_WR, C_MEM_WR, C_MEM_WR};
      rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      bus.opcode = OP_STORE;
      for (int i = 0; i < 7; i++) begin
         bus.mem_ready = rdy[i];
         #1;
         n_checks++; if (dut.state !== st[i]) begin n_fail++; $display("FAIL sw_edge_state c%0d got %0d want %0d", i, dut.state, st[i]); end
         n_checks++; if (ctl !== ec[i]) begin n_fail++; $display("FAIL sw_edge_ctl c%0d got %b want %b", i, ctl, ec[i]); end
         @(negedge clk);
      end
      #1;
      n_checks++; if (dut.state !== FETCH || retired !== 4'd1 || trap !== 1'b0) begin
         n_fail++; $display("FAIL sw_edge_retire got state=%0d retired=%0d trap=%b want %0d/1/0", dut.state, retired, trap, FETCH); end
   endtask

   task automatic test_sw_timeout();
      state_t      st  [7];
      logic [12:0] ec  [7];
      logic        rdy [7];
      st  = '{FETCH, DECODE, MEM_ADDR, MEM_WR, MEM_WR, MEM_WR, MEM_WR};
      ec  = '{C_FETCH_GO, C_IDLE, C_MEM_ADDR, C_MEM_WR, C_MEM_WR, C_MEM_WR, C_MEM_WR};
      rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      bus.opcode = OP_STORE;
      for (int i = 0; i < 7; i++) begin
         bus.mem_ready = rdy[i];
         #1;
         n_checks++; if (dut.state !== st[i]) begin n_fail++; $display("FAIL sw_to_state c%0d got %0d want %0d", i, dut.state, st[i]); end
         n_checks++; if (ctl !== ec[i]) begin n_fail++; $display("FAIL sw_to_ctl c%0d got %b want %b", i, ctl, ec[i]); end
         @(negedge clk);
      end
      #1;
      n_checks++; if (dut.state !== TRAP || ctl !== C_TRAP) begin
         n_fail++; $display("FAIL sw_to_trap got state=%0d ctl=%b want %0d/%b", dut.state, ctl, TRAP, C_TRAP); end
      n_checks++; if (trap_cause !== 2'b10 || retired !== 4'd1) begin
         n_fail++; $display("FAIL sw_to_cause got cause=%b retired=%0d want 10/1", trap_cause, retired); end
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      n_checks++; if (dut.state !== RST || trap !== 1'b0 || trap_cause !== 2'b00) begin
         n_fail++; $display("FAIL sw_to_clear got state=%0d trap=%b cause=%b want %0d/0/00", dut.state, trap, trap_cause, RST); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_illegal();
      bus.opcode = 7'b1111111; bus.mem_ready = 1'b1;
      #1;
      n_checks++; if (dut.state !== FETCH || ctl !== C_FETCH_GO) begin
         n_fail++; $display("FAIL ill_fetch got state=%0d ctl=%b want %0d/%b", dut.state, ctl, FETCH, C_FETCH_GO); end
      @(negedge clk);
      #1;
      n_checks++; if (dut.state !== DECODE || ctl !== C_IDLE) begin
         n_fail++; $display("FAIL ill_decode got state=%0d ctl=%b want %0d/%b", dut.state, ctl, DECODE, C_IDLE); end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.mem_ready = i[0];
         bus.zero      = i[1];
         #1;
         n_checks++; if (dut.state !== TRAP || ctl !== C_TRAP || trap_cause !== 2'b01) begin
            n_fail++; $display("FAIL ill_hold c%0d got state=%0d ctl=%b cause=%b want %0d/%b/01", i, dut.state, ctl, trap_cause, TRAP, C_TRAP); end
      end
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      n_checks++; if (dut.state !== RST || ctl !== C_IDLE) begin
         n_fail++; $display("FAIL ill_rst got state=%0d ctl=%b want %0d/%b", dut.state, ctl, RST, C_IDLE); end
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_checks++; if (dut.state !== FETCH || retired !== 4'd0) begin
         n_fail++; $display("FAIL ill_fetch_after got state=%0d retired=%0d want %0d/0", dut.state, retired, FETCH); end
   endtask

   task automatic test_reset_mid_write();
      bus.opcode = OP_STORE; bus.mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      n_checks++; if (dut.state !== MEM_WR || ctl !== C_MEM_WR) begin
         n_fail++; $display("FAIL rmw_pre got state=%0d ctl=%b want %0d/%b", dut.state, ctl, MEM_WR, C_MEM_WR); end
      rst_n = 1'b0;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      #1;
      n_checks++; if (dut.state !== RST || bus.mem_write !== 1'b0 || ctl !== C_IDLE) begin
         n_fail++; $display("FAIL rmw_abort got state=%0d ctl=%b want %0d/%b", dut.state, ctl, RST, C_IDLE); end
      n_checks++; if (retired !== 4'd0 || trap !== 1'b0) begin
         n_fail++; $display("FAIL rmw_regs got retired=%0d trap=%b want 0/0", retired, trap); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw();
      test_beq();
      test_wrap();
      test_sw_ready_at_limit();
      test_sw_timeout();
      test_illegal();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
